// File: rtl/window_feeder.sv
// Streams raster-order pixels into an NxN sliding window using N-1 line buffers.
// Define WINDOW_FEEDER_LAST_EN to add out_last, flagging the final window of each frame.
module window_feeder #(
    parameter int N          = 3,
    parameter int BitSize    = 8,
    parameter int ImageWidth = 16
) (
    input  logic                         clk,
    input  logic                         res,
    input  logic                         in_valid,
    input  logic [BitSize-1:0]           in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [(N*N)*BitSize-1:0]     out_data,
    input  logic                         out_ready
`ifdef WINDOW_FEEDER_LAST_EN
    ,
    output logic                         out_last
`endif
);

    localparam int CW = (ImageWidth > 1) ? $clog2(ImageWidth) : 1;
    localparam logic [CW-1:0] LastPos = CW'(ImageWidth - 1);
    localparam logic [CW-1:0] EdgePos = CW'(N - 1);

    logic [CW-1:0]      row;
    logic [CW-1:0]      col;
    logic               accept;
    logic               complete;
    logic               col_end;
    logic               frame_end;
    logic [BitSize-1:0] win     [N][N];
    logic [BitSize-1:0] new_col [N];

    // A stalled window blocks intake so the window register cannot move under it.
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign col_end   = (col == LastPos);
    assign frame_end = col_end && (row == LastPos);
    assign complete  = (row >= EdgePos) && (col >= EdgePos);

    generate
        if (N > 1) begin : g_lines
            logic [BitSize-1:0] line_buf [N-1][ImageWidth];

            // Entry 0 holds the oldest row; each column slot ages upward on acceptance.
            always_comb begin
                for (int r = 0; r < N - 1; r++) begin
                    new_col[r] = line_buf[r][col];
                end
                new_col[N-1] = in_data;
            end

            always_ff @(posedge clk) begin
                if (accept) begin
                    for (int i = 0; i < N - 2; i++) begin
                        line_buf[i][col] <= line_buf[i+1][col];
                    end
                    line_buf[N-2][col] <= in_data;
                end
            end
        end else begin : g_no_lines
            always_comb begin
                new_col[0] = in_data;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (col_end) begin
                col <= '0;
                row <= (row == LastPos) ? '0 : row + CW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N - 1; c++) begin
                    win[r][c] <= win[r][c+1];
                end
                win[r][N-1] <= new_col[r];
            end
        end
    end

    // A new window replaces a transferring one on the same edge without a gap.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= complete;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef WINDOW_FEEDER_LAST_EN
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            out_last <= 1'b0;
        end else if (accept) begin
            out_last <= complete && frame_end;
        end else if (out_ready) begin
            out_last <= 1'b0;
        end
    end
`endif

    always_comb begin
        out_data = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                out_data[(r*N + c)*BitSize +: BitSize] = win[r][c];
            end
        end
    end

endmodule

// File: tb/tb_window_feeder.sv
// Scoreboard bench for window_feeder: an image-array reference model predicts windows,
// handshakes and (with WINDOW_FEEDER_LAST_EN) the frame-last flag.
module tb_window_feeder;

    localparam int N  = 3;
    localparam int BW = 8;
    localparam int IW = 4;
    localparam int WB = N*N*BW;

    logic          clk = 1'b0;
    logic          res;
    logic          in_valid;
    logic [BW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [WB-1:0] out_data;
    logic          out_ready;
    logic          out_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    window_feeder #(.N(N), .BitSize(BW), .ImageWidth(IW)) dut (
        .clk       (clk),
        .res       (res),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef WINDOW_FEEDER_LAST_EN
        ,
        .out_last  (out_last)
`endif
    );

`ifndef WINDOW_FEEDER_LAST_EN
    assign out_last = 1'b0;
`endif

    // Reference model state: the frame as a 2-D image plus pending expected windows.
    logic [BW-1:0] img [IW][IW];
    logic [WB-1:0] exp_q[$];
    bit            exp_last_q[$];
    logic [WB-1:0] log_q[$];
    bit            log_last_q[$];
    bit            exp_valid = 1'b0;
    int            pix_idx   = 0;
    bit            stop_rand = 1'b0;

    task automatic check_output(input string name, input logic [WB-1:0] act, input logic [WB-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [WB-1:0] win_corner(input int base, input int corner);
        logic [WB-1:0] w;
        w = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                w[(i*N + j)*BW +: BW] = BW'(base + corner + i*IW + j);
            end
        end
        return w;
    endfunction

    // Scoreboard monitor: samples mid-cycle, predicts what the next edge does.
    always @(negedge clk) begin
        bit            acc;
        int            r;
        int            c;
        logic [WB-1:0] w;
        if (res) begin
            exp_q.delete();
            exp_last_q.delete();
            exp_valid = 1'b0;
            pix_idx   = 0;
        end else begin
            check_output("in_ready", WB'(in_ready), WB'(!exp_valid || out_ready));
            check_output("out_valid", WB'(out_valid), WB'(exp_valid));
            acc = in_valid && (!exp_valid || out_ready);
            if (exp_valid) begin
                if (exp_q.size() == 0) begin
                    check_output("queue_nonempty", WB'(0), WB'(1));
                end else begin
                    check_output("window", out_data, exp_q[0]);
`ifdef WINDOW_FEEDER_LAST_EN
                    check_output("out_last", WB'(out_last), WB'(exp_last_q[0]));
`endif
                    if (out_ready) begin
                        log_q.push_back(out_data);
                        log_last_q.push_back(out_last);
                        void'(exp_q.pop_front());
                        void'(exp_last_q.pop_front());
                    end
                end
            end
            if (acc) begin
                r = pix_idx / IW;
                c = pix_idx % IW;
                img[r][c] = in_data;
                if (r >= N-1 && c >= N-1) begin
                    w = '0;
                    for (int i = 0; i < N; i++) begin
                        for (int j = 0; j < N; j++) begin
                            w[(i*N + j)*BW +: BW] = img[r-N+1+i][c-N+1+j];
                        end
                    end
                    exp_q.push_back(w);
                    exp_last_q.push_back(pix_idx == IW*IW - 1);
                    exp_valid = 1'b1;
                end else begin
                    exp_valid = 1'b0;
                end
                pix_idx = (pix_idx + 1) % (IW*IW);
            end else if (out_ready) begin
                exp_valid = 1'b0;
            end
        end
    end

    task automatic send_pixel(input logic [BW-1:0] v, input bit rand_gap);
        int budget;
        bit done;
        if (rand_gap) begin
            while ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_data  = v;
        budget   = 0;
        done     = 1'b0;
        while (!done) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
            budget++;
            if (!done && budget > 200) begin
                checks++;
                errors++;
                $display("[TB] FAIL accept_timeout actual=stalled required=accepted");
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic apply_stimulus(input int base, input bit rand_gap, input bit rand_data);
        for (int i = 0; i < IW*IW; i++) begin
            send_pixel(rand_data ? BW'($urandom) : BW'(base + i), rand_gap);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input int first, input int base);
        check_output("corner0", log_q[first],     win_corner(base, 0));
        check_output("corner1", log_q[first + 1], win_corner(base, 1));
        check_output("corner4", log_q[first + 2], win_corner(base, 4));
        check_output("corner5", log_q[first + 3], win_corner(base, 5));
`ifdef WINDOW_FEEDER_LAST_EN
        check_output("last_first", WB'(log_last_q[first]),     WB'(0));
        check_output("last_final", WB'(log_last_q[first + 3]), WB'(1));
`endif
    endtask

    initial begin
        res       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_in_ready", WB'(in_ready), WB'(1));
        check_output("rst_out_valid", WB'(out_valid), WB'(0));
        check_output("rst_out_data", out_data, '0);
        res = 1'b0;

        // Plain frame, downstream always ready
        log_q.delete(); log_last_q.delete();
        apply_stimulus(0, 1'b0, 1'b0);
        drain();
        check_output("count_plain", WB'(log_q.size()), WB'(4));
        if (log_q.size() == 4) check_frame(0, 0);

        // Downstream stall for 5 cycles after the first window
        log_q.delete(); log_last_q.delete();
        out_ready = 1'b0;
        fork
            apply_stimulus(0, 1'b0, 1'b0);
            begin
                int budget;
                budget = 0;
                while (!out_valid && budget < 100) begin
                    @(negedge clk);
                    budget++;
                end
                check_output("stall_seen", WB'(out_valid), WB'(1));
                for (int k = 0; k < 5; k++) begin
                    check_output("stall_data", out_data, win_corner(0, 0));
                    check_output("stall_ready", WB'(in_ready), WB'(0));
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check_output("count_stall", WB'(log_q.size()), WB'(4));
        if (log_q.size() == 4) check_frame(0, 0);

        // Two frames back to back
        log_q.delete(); log_last_q.delete();
        apply_stimulus(0, 1'b0, 1'b0);
        apply_stimulus(100, 1'b0, 1'b0);
        drain();
        check_output("count_b2b", WB'(log_q.size()), WB'(8));
        if (log_q.size() == 8) begin
            check_frame(0, 0);
            check_frame(4, 100);
        end

        // Reset mid-frame with a window pending
        for (int i = 0; i < 11; i++) send_pixel(BW'(i), 1'b0);
        res = 1'b1;
        #1;
        check_output("midrst_valid", WB'(out_valid), WB'(0));
        check_output("midrst_data", out_data, '0);
        @(posedge clk);
        #1;
        res = 1'b0;
        log_q.delete(); log_last_q.delete();
        apply_stimulus(0, 1'b0, 1'b0);
        drain();
        check_output("count_midrst", WB'(log_q.size()), WB'(4));
        if (log_q.size() == 4) check_frame(0, 0);

        // Random in_valid gaps, out_ready held high
        log_q.delete(); log_last_q.delete();
        apply_stimulus(0, 1'b1, 1'b0);
        drain();
        check_output("count_gaps", WB'(log_q.size()), WB'(4));
        if (log_q.size() == 4) check_frame(0, 0);

        // Random data, gaps and back-pressure across several frames
        log_q.delete(); log_last_q.delete();
        stop_rand = 1'b0;
        fork
            begin
                for (int f = 0; f < 3; f++) apply_stimulus(0, 1'b1, 1'b1);
                stop_rand = 1'b1;
            end
            begin
                while (!stop_rand) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();
        check_output("count_random", WB'(log_q.size()), WB'(12));
        check_output("queue_empty", WB'(exp_q.size()), WB'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
